risc_boot_loader: RTL and testbench

//  Upstream stage of the 16-bit RISC core (Risc_16_bit). Accepts a byte stream from a host link
//  (UART RX or bench driver), packs bytes into 16-bit instruction words and writes them into

---
 rtl/risc_boot_loader_pkg.sv | 19 +
 rtl/risc_boot_loader_byte_pack.sv | 50 +++++
 rtl/risc_boot_loader.sv | 156 +++++++++++++++
 tb/tb_risc_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_boot_loader_pkg.sv
// Shared definitions for the boot loader: loader FSM state encodings,
// default instruction-memory geometry and the checksum seed value.
package risc_boot_loader_pkg;

    localparam int         BOOT_ADDR_W     = 4;
    localparam int         BOOT_IMEM_DEPTH = 16;
    localparam logic [7:0] BOOT_CSUM_INIT  = 8'h00;

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_CSUM    = 3'd4,
        S_RUN     = 3'd5,
        S_ERR     = 3'd6
    } boot_state_t;

endpackage

// File: rtl/risc_boot_loader_byte_pack.sv
// Byte-to-word packer for the boot loader. Latches the high byte of each
// instruction word, assembles {hi, lo} on the low byte, accumulates the XOR
// checksum of all data bytes, and emits a one-cycle word-ready strobe.
// Ports:
//   clk, reset   clock and async active-low reset
//   clr          clears the hi latch and the checksum (loader re-arm)
//   hi_en        high data byte accepted this cycle
//   lo_en        low data byte accepted this cycle
//   in_data      host byte
//   csum         running XOR of data bytes
//   word_ready   registered strobe, high the cycle after a low byte
//   word         registered {hi, lo}
module risc_boot_loader_byte_pack
    import risc_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        hi_en,
    input  logic        lo_en,
    input  logic [7:0]  in_data,
    output logic [7:0]  csum,
    output logic        word_ready,
    output logic [15:0] word
);

    logic [7:0] hi_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_byte    <= 8'h00;
            csum       <= BOOT_CSUM_INIT;
            word_ready <= 1'b0;
            word       <= 16'h0000;
        end else begin
            word_ready <= lo_en;
            if (clr) begin
                hi_byte <= 8'h00;
                csum    <= BOOT_CSUM_INIT;
            end else if (hi_en) begin
                hi_byte <= in_data;
                csum    <= csum ^ in_data;
            end else if (lo_en) begin
                word    <= {hi_byte, in_data};
                csum    <= csum ^ in_data;
            end
        end
    end

endmodule

// File: rtl/risc_boot_loader.sv
// Boot loader for the 16-bit RISC core. Receives a length-framed,
// XOR-checksummed byte image, writes it into instruction memory word by
// word and holds the core in reset until the image verifies.
//
// state     | meaning
// S_LEN_HI  | waiting for high byte of word count N
// S_LEN_LO  | waiting for low byte of N; range check
// S_DATA_HI | waiting for high byte of next word
// S_DATA_LO | waiting for low byte; issues memory write
// S_CSUM    | waiting for checksum byte
// S_RUN     | image good, core released
// S_ERR     | bad length or checksum, core held
//
// Ports:
//   clk, reset        clock and async active-low reset
//   in_data/valid/    host byte stream (transfer on valid & ready)
//   in_ready
//   start             re-arm pulse, honoured only in S_RUN / S_ERR
//   im_we/addr/wdata  instruction-memory write port
//   cpu_reset         core reset, low only in S_RUN
//   done, err         status flags
//   words_loaded      words written during the current load
module risc_boot_loader
    import risc_boot_loader_pkg::*;
#(
    parameter int ADDR_W     = BOOT_ADDR_W,
    parameter int IMEM_DEPTH = BOOT_IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [15:0]   MAX_LEN = 16'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    boot_state_t     state;
    logic [7:0]      len_hi;
    logic [ADDR_W:0] words_left;
    logic [15:0]     len_n;
    logic            accept;
    logic            hi_en;
    logic            lo_en;
    logic            rearm;
    logic [7:0]      csum;

    assign accept = in_valid & in_ready;
    assign hi_en  = accept && (state == S_DATA_HI);
    assign lo_en  = accept && (state == S_DATA_LO);
    assign rearm  = start && ((state == S_RUN) || (state == S_ERR));
    assign len_n  = {len_hi, in_data};

    risc_boot_loader_byte_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clr        (rearm),
        .hi_en      (hi_en),
        .lo_en      (lo_en),
        .in_data    (in_data),
        .csum       (csum),
        .word_ready (im_we),
        .word       (im_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_LEN_HI;
            len_hi       <= 8'h00;
            words_left   <= '0;
            in_ready     <= 1'b1;
            im_addr      <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= in_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        // Range check here guarantees the word index never wraps.
                        if (len_n > MAX_LEN) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (len_n == 16'h0000) begin
                            state <= S_CSUM;
                        end else begin
                            words_left <= len_n[ADDR_W:0];
                            state      <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        state <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        im_addr      <= words_loaded[ADDR_W-1:0];
                        words_loaded <= words_loaded + ONE;
                        words_left   <= words_left - ONE;
                        state        <= (words_left == ONE) ? S_CSUM : S_DATA_HI;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= S_RUN;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_RUN, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN_HI;
                        in_ready     <= 1'b1;
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_left   <= '0;
                        im_addr      <= '0;
                        words_loaded <= '0;
                    end
                end
                default: begin
                    state     <= S_LEN_HI;
                    in_ready  <= 1'b1;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_boot_loader.sv
module tb_risc_boot_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        im_we;
    logic [3:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;
    logic [4:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    logic [7:0] frame_q[$];
    int         exp_addr[$];
    int         exp_data[$];
    int         got_addr[$];
    int         got_data[$];
    bit         m_done;
    int         m_wl;

    typedef struct {
        logic [15:0] len;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  csum;
        bit          exp_done;
        int          exp_wl;
    } vec_t;

    vec_t vt[7];

    risc_boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && im_we) begin
            got_addr.push_back(int'(im_addr));
            got_data.push_back(int'(im_wdata));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: parse the frame by the framing rules and predict writes and outcome.
    task automatic model_frame(input logic [7:0] fb[$]);
        int         n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        x = 8'h00;
        n = int'({fb[0], fb[1]});
        if (n > 16) begin
            m_done = 1'b0;
            m_wl   = 0;
        end else begin
            for (int j = 0; j < n; j++) begin
                x = x ^ fb[2 + 2*j] ^ fb[3 + 2*j];
                exp_addr.push_back(j);
                exp_data.push_back(int'({fb[2 + 2*j], fb[3 + 2*j]}));
            end
            m_wl   = n;
            m_done = (fb[2 + 2*n] == x);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waitc = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout: in_ready=0 required 1 (byte %02h)", b);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input int gap_max, input bit rand_start);
        int g;
        model_frame(frame_q);
        foreach (frame_q[k]) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                start = rand_start && ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            start = 1'b0;
            send_byte(frame_q[k]);
        end
    endtask

    task automatic check_outcome(input string tag, input bit exp_done, input int exp_wl);
        int m;
        chk({tag, ".done"},      32'(done),         32'(exp_done));
        chk({tag, ".err"},       32'(err),          32'(!exp_done));
        chk({tag, ".cpu_reset"}, 32'(cpu_reset),    32'(!exp_done));
        chk({tag, ".in_ready"},  32'(in_ready),     32'(0));
        chk({tag, ".words"},     32'(words_loaded), 32'(exp_wl));
        chk({tag, ".nwrites"},   32'(got_addr.size()), 32'(exp_addr.size()));
        m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s.addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s.data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
        end
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".rearm_cpu_reset"}, 32'(cpu_reset),    32'(1));
        chk({tag, ".rearm_done"},      32'(done),         32'(0));
        chk({tag, ".rearm_err"},       32'(err),          32'(0));
        chk({tag, ".rearm_in_ready"},  32'(in_ready),     32'(1));
        chk({tag, ".rearm_words"},     32'(words_loaded), 32'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".cpu_reset"}, 32'(cpu_reset),    32'(1));
        chk({tag, ".in_ready"},  32'(in_ready),     32'(1));
        chk({tag, ".im_we"},     32'(im_we),        32'(0));
        chk({tag, ".im_addr"},   32'(im_addr),      32'(0));
        chk({tag, ".im_wdata"},  32'(im_wdata),     32'(0));
        chk({tag, ".done"},      32'(done),         32'(0));
        chk({tag, ".err"},       32'(err),          32'(0));
        chk({tag, ".words"},     32'(words_loaded), 32'(0));
    endtask

    task automatic build_vec(input vec_t v);
        frame_q.delete();
        frame_q.push_back(v.len[15:8]);
        frame_q.push_back(v.len[7:0]);
        if (v.len <= 16'd16) begin
            for (int j = 0; j < int'(v.len); j++) begin
                frame_q.push_back((j == 0) ? v.w0[15:8] : v.w1[15:8]);
                frame_q.push_back((j == 0) ? v.w0[7:0]  : v.w1[7:0]);
            end
            frame_q.push_back(v.csum);
        end
    endtask

    initial begin
        // 0x12^0x34^0xAB^0xCD = 0x40; 0x00^0xFF = 0xFF
        vt[0] = '{16'h0002, 16'h1234, 16'hABCD, 8'h40, 1'b1, 2};
        vt[1] = '{16'h0002, 16'h1234, 16'hABCD, 8'h41, 1'b0, 2};
        vt[2] = '{16'h0011, 16'h0000, 16'h0000, 8'h00, 1'b0, 0};
        vt[3] = '{16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b1, 0};
        vt[4] = '{16'h0000, 16'h0000, 16'h0000, 8'h5A, 1'b0, 0};
        vt[5] = '{16'h0001, 16'h00FF, 16'h0000, 8'hFF, 1'b1, 1};
        vt[6] = '{16'h0100, 16'h0000, 16'h0000, 8'h00, 1'b0, 0};

        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        start    = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            build_vec(vt[i]);
            run_frame(0, 1'b0);
            check_outcome($sformatf("vec%0d", i), vt[i].exp_done, vt[i].exp_wl);
            pulse_start($sformatf("vec%0d", i));
        end

        // Reset mid-data after 1 of 3 words, then a fresh load from address 0.
        frame_q = '{8'h00, 8'h03, 8'h11, 8'h22};
        foreach (frame_q[k]) send_byte(frame_q[k]);
        @(negedge clk);
        chk("midreset.prewrites", 32'(got_addr.size()), 32'(1));
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b1;
        got_addr.delete();
        got_data.delete();
        @(negedge clk);
        frame_q = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        run_frame(0, 1'b0);
        check_outcome("afterreset", 1'b1, 1);
        pulse_start("afterreset");

        // Full-depth image with random valid gaps and ignored start pulses.
        frame_q.delete();
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h10);
        begin
            logic [7:0] x = 8'h00;
            logic [7:0] b;
            for (int j = 0; j < 32; j++) begin
                b = 8'($urandom);
                x = x ^ b;
                frame_q.push_back(b);
            end
            frame_q.push_back(x);
        end
        run_frame(3, 1'b1);
        check_outcome("full16", m_done, m_wl);
        chk("full16.model_done", 32'(done), 32'(1));

        // start together with in_valid in RUN: the byte must not be taken.
        in_data  = 8'h00;
        in_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("startvalid.in_ready", 32'(in_ready), 32'(1));
        chk("startvalid.done",     32'(done),     32'(0));
        frame_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        run_frame(0, 1'b0);
        check_outcome("startvalid", 1'b1, 1);
        pulse_start("startvalid");

        // Randomised frames, some with corrupted checksum.
        for (int r = 0; r < 6; r++) begin
            int         n;
            logic [7:0] x;
            logic [7:0] b;
            n = int'($urandom_range(0, 16));
            x = 8'h00;
            frame_q.delete();
            frame_q.push_back(8'h00);
            frame_q.push_back(8'(n));
            for (int j = 0; j < 2*n; j++) begin
                b = 8'($urandom);
                x = x ^ b;
                frame_q.push_back(b);
            end
            if ($urandom_range(0, 1) == 1) x = x ^ 8'(1 << $urandom_range(0, 7));
            frame_q.push_back(x);
            run_frame(2, 1'b1);
            check_outcome($sformatf("rand%0d", r), m_done, m_wl);
            pulse_start($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
